// File: rtl/ex_mem_stage.sv
// RV32 execute stage: operand forwarding, ALU, and the EX/MEM register (1 cycle EX->M).
// No valid/ready handshake: the hazard unit holds the register with StallM and bubbles it with FlushM.
module ex_mem_stage #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             StallM,
  input  logic             FlushM,
  input  logic             ValidE,
  input  logic [2:0]       ALUControlE,
  input  logic             ALUSrcE,
  input  logic [1:0]       ForwardAE,
  input  logic [1:0]       ForwardBE,
  input  logic [WIDTH-1:0] RD1E,
  input  logic [WIDTH-1:0] RD2E,
  input  logic [WIDTH-1:0] ImmExtE,
  input  logic [WIDTH-1:0] ResultW,
  input  logic [4:0]       RdE,
  input  logic             RegWriteE,
  input  logic             MemWriteE,
  input  logic [1:0]       ResultSrcE,
  output logic             ZeroE,
  output logic [WIDTH-1:0] ALUResultM,
  output logic [WIDTH-1:0] WriteDataM,
  output logic [4:0]       RdM,
  output logic             RegWriteM,
  output logic             MemWriteM,
  output logic [1:0]       ResultSrcM,
  output logic             ValidM
);

  logic [WIDTH-1:0] src_a, fwd_b, src_b, diff, alu_result;
  logic             ovf;

  logic [WIDTH-1:0] alu_result_d, alu_result_q;
  logic [WIDTH-1:0] write_data_d, write_data_q;
  logic [4:0]       rd_d, rd_q;
  logic             reg_write_d, reg_write_q;
  logic             mem_write_d, mem_write_q;
  logic [1:0]       result_src_d, result_src_q;
  logic             valid_d, valid_q;

  // Code 11 is reserved and falls back to the register-file value.
  always_comb begin
    case (ForwardAE)
      2'b01:   src_a = ResultW;
      2'b10:   src_a = alu_result_q;
      default: src_a = RD1E;
    endcase
    case (ForwardBE)
      2'b01:   fwd_b = ResultW;
      2'b10:   fwd_b = alu_result_q;
      default: fwd_b = RD2E;
    endcase
    src_b = ALUSrcE ? ImmExtE : fwd_b;
  end

  // slt corrects the difference sign with the signed-overflow bit so extremes compare correctly.
  always_comb begin
    diff       = src_a - src_b;
    ovf        = (src_a[WIDTH-1] ^ src_b[WIDTH-1]) & (diff[WIDTH-1] ^ src_a[WIDTH-1]);
    alu_result = '0;
    case (ALUControlE)
      3'b000:  alu_result = src_a + src_b;
      3'b001:  alu_result = diff;
      3'b010:  alu_result = src_a & src_b;
      3'b011:  alu_result = src_a | src_b;
      3'b101:  alu_result = {{(WIDTH-1){1'b0}}, diff[WIDTH-1] ^ ovf};
      default: alu_result = '0;
    endcase
  end

  assign ZeroE = (alu_result == '0);

  always_comb begin
    alu_result_d = alu_result_q;
    write_data_d = write_data_q;
    rd_d         = rd_q;
    reg_write_d  = reg_write_q;
    mem_write_d  = mem_write_q;
    result_src_d = result_src_q;
    valid_d      = valid_q;
    if (FlushM) begin
      alu_result_d = '0;
      write_data_d = '0;
      rd_d         = '0;
      reg_write_d  = 1'b0;
      mem_write_d  = 1'b0;
      result_src_d = '0;
      valid_d      = 1'b0;
    end else if (!StallM) begin
      alu_result_d = alu_result;
      write_data_d = fwd_b;
      rd_d         = RdE;
      reg_write_d  = RegWriteE & ValidE;
      mem_write_d  = MemWriteE & ValidE;
      result_src_d = ResultSrcE;
      valid_d      = ValidE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alu_result_q <= '0;
      write_data_q <= '0;
      rd_q         <= '0;
      reg_write_q  <= 1'b0;
      mem_write_q  <= 1'b0;
      result_src_q <= '0;
      valid_q      <= 1'b0;
    end else begin
      alu_result_q <= alu_result_d;
      write_data_q <= write_data_d;
      rd_q         <= rd_d;
      reg_write_q  <= reg_write_d;
      mem_write_q  <= mem_write_d;
      result_src_q <= result_src_d;
      valid_q      <= valid_d;
    end
  end

  assign ALUResultM = alu_result_q;
  assign WriteDataM = write_data_q;
  assign RdM        = rd_q;
  assign RegWriteM  = reg_write_q;
  assign MemWriteM  = mem_write_q;
  assign ResultSrcM = result_src_q;
  assign ValidM     = valid_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed bench for ex_mem_stage: vector table plus stall, flush and async-reset sequences.
module tb_ex_mem_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        StallM, FlushM, ValidE, ALUSrcE;
  logic [2:0]  ALUControlE;
  logic [1:0]  ForwardAE, ForwardBE, ResultSrcE;
  logic [31:0] RD1E, RD2E, ImmExtE, ResultW;
  logic [4:0]  RdE;
  logic        RegWriteE, MemWriteE;
  logic        ZeroE;
  logic [31:0] ALUResultM, WriteDataM;
  logic [4:0]  RdM;
  logic        RegWriteM, MemWriteM, ValidM;
  logic [1:0]  ResultSrcM;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  ex_mem_stage #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .StallM(StallM), .FlushM(FlushM), .ValidE(ValidE),
    .ALUControlE(ALUControlE), .ALUSrcE(ALUSrcE), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE), .ResultW(ResultW), .RdE(RdE),
    .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .ResultSrcE(ResultSrcE), .ZeroE(ZeroE),
    .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .RdM(RdM), .RegWriteM(RegWriteM),
    .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM), .ValidM(ValidM)
  );

  typedef struct {
    logic [2:0]  ctl;
    logic        src;
    logic [1:0]  fa, fb;
    logic [31:0] rd1, rd2, imm, resw;
    logic        regw, memw, valid;
    logic [31:0] e_alu, e_wd;
    logic [2:0]  e_flags;  // {valid, regwrite, memwrite}
    logic        e_zero;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic [2:0] ctl, logic src, logic [1:0] fa, logic [1:0] fb,
                              logic [31:0] rd1, logic [31:0] rd2, logic [31:0] imm,
                              logic [31:0] resw, logic regw, logic memw, logic valid,
                              logic [31:0] e_alu, logic [31:0] e_wd, logic [2:0] e_flags,
                              logic e_zero);
    vec_t v;
    v.ctl = ctl; v.src = src; v.fa = fa; v.fb = fb;
    v.rd1 = rd1; v.rd2 = rd2; v.imm = imm; v.resw = resw;
    v.regw = regw; v.memw = memw; v.valid = valid;
    v.e_alu = e_alu; v.e_wd = e_wd; v.e_flags = e_flags; v.e_zero = e_zero;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h, expected %h", name, act, exp);
    else passed++;
  endtask

  task automatic chk_m(input string tag, input logic [31:0] e_alu, input logic [31:0] e_wd,
                       input logic [4:0] e_rd, input logic [1:0] e_rsrc, input logic [2:0] e_flags);
    chk({tag, ".ALUResultM"}, ALUResultM, e_alu);
    chk({tag, ".WriteDataM"}, WriteDataM, e_wd);
    chk({tag, ".RdM"}, {27'd0, RdM}, {27'd0, e_rd});
    chk({tag, ".ResultSrcM"}, {30'd0, ResultSrcM}, {30'd0, e_rsrc});
    chk({tag, ".ValidM"}, {31'd0, ValidM}, {31'd0, e_flags[2]});
    chk({tag, ".RegWriteM"}, {31'd0, RegWriteM}, {31'd0, e_flags[1]});
    chk({tag, ".MemWriteM"}, {31'd0, MemWriteM}, {31'd0, e_flags[0]});
  endtask

  task automatic drive(input vec_t v, input logic [4:0] rd, input logic [1:0] rsrc);
    ALUControlE = v.ctl; ALUSrcE = v.src; ForwardAE = v.fa; ForwardBE = v.fb;
    RD1E = v.rd1; RD2E = v.rd2; ImmExtE = v.imm; ResultW = v.resw;
    RegWriteE = v.regw; MemWriteE = v.memw; ValidE = v.valid;
    RdE = rd; ResultSrcE = rsrc;
  endtask

  initial begin
    //            ctl    src fa     fb     rd1           rd2           imm        resw       rw mw v  e_alu         e_wd          flags  z
    vecs.push_back(mk(3'b000,0,2'b00,2'b00,32'h7FFFFFFF,32'h00000001,32'h0,     32'h0,     1,0,1, 32'h80000000,32'h00000001,3'b110,0));
    vecs.push_back(mk(3'b101,0,2'b00,2'b00,32'h80000000,32'h00000001,32'h0,     32'h0,     1,0,1, 32'h00000001,32'h00000001,3'b110,0));
    vecs.push_back(mk(3'b101,0,2'b00,2'b00,32'h00000001,32'h80000000,32'h0,     32'h0,     1,0,1, 32'h00000000,32'h80000000,3'b110,1));
    vecs.push_back(mk(3'b101,0,2'b00,2'b00,32'h00000005,32'h00000005,32'h0,     32'h0,     1,0,1, 32'h00000000,32'h00000005,3'b110,1));
    vecs.push_back(mk(3'b000,0,2'b00,2'b00,32'h00000002,32'h00000003,32'h0,     32'h0,     1,0,1, 32'h00000005,32'h00000003,3'b110,0));
    vecs.push_back(mk(3'b000,0,2'b10,2'b00,32'h00000100,32'h00000003,32'h0,     32'h0,     1,0,1, 32'h00000008,32'h00000003,3'b110,0));
    vecs.push_back(mk(3'b000,0,2'b00,2'b01,32'h00000001,32'h00000000,32'h0,     32'h9,     0,1,1, 32'h0000000A,32'h00000009,3'b101,0));
    vecs.push_back(mk(3'b001,0,2'b00,2'b00,32'h00000003,32'h00000005,32'h0,     32'h0,     1,0,1, 32'hFFFFFFFE,32'h00000005,3'b110,0));
    vecs.push_back(mk(3'b010,0,2'b00,2'b00,32'h0000F0F0,32'h0000FF00,32'h0,     32'h0,     1,0,1, 32'h0000F000,32'h0000FF00,3'b110,0));
    vecs.push_back(mk(3'b011,0,2'b00,2'b00,32'h0000F0F0,32'h00000F0F,32'h0,     32'h0,     1,0,1, 32'h0000FFFF,32'h00000F0F,3'b110,0));
    vecs.push_back(mk(3'b110,0,2'b00,2'b00,32'h00000003,32'h00000004,32'h0,     32'h0,     1,0,1, 32'h00000000,32'h00000004,3'b110,1));
    vecs.push_back(mk(3'b000,1,2'b00,2'b00,32'h00000001,32'h0000DEAD,32'h100,   32'h0,     0,1,1, 32'h00000101,32'h0000DEAD,3'b101,0));
    vecs.push_back(mk(3'b000,0,2'b00,2'b00,32'h00000001,32'h00000001,32'h0,     32'h0,     1,1,0, 32'h00000002,32'h00000001,3'b000,0));
    vecs.push_back(mk(3'b000,0,2'b11,2'b11,32'h00000004,32'h00000006,32'h0,     32'h55,    1,0,1, 32'h0000000A,32'h00000006,3'b110,0));
    vecs.push_back(mk(3'b101,0,2'b00,2'b00,32'hFFFFFFFF,32'h00000001,32'h0,     32'h0,     1,0,1, 32'h00000001,32'h00000001,3'b110,0));
    vecs.push_back(mk(3'b101,0,2'b00,2'b00,32'h7FFFFFFF,32'hFFFFFFFF,32'h0,     32'h0,     1,0,1, 32'h00000000,32'hFFFFFFFF,3'b110,1));
    vecs.push_back(mk(3'b100,0,2'b00,2'b00,32'h00000003,32'h00000004,32'h0,     32'h0,     1,0,1, 32'h00000000,32'h00000004,3'b110,1));
    vecs.push_back(mk(3'b111,0,2'b00,2'b00,32'h00000003,32'h00000004,32'h0,     32'h0,     1,0,1, 32'h00000000,32'h00000004,3'b110,1));

    reset = 1'b1; StallM = 0; FlushM = 0;
    drive(mk(3'b000,0,2'b00,2'b00,32'h0,32'h0,32'h0,32'h0,0,0,0,32'h0,32'h0,3'b000,0), 5'd0, 2'd0);
    repeat (2) @(posedge clk);
    #1;
    chk_m("reset", 32'h0, 32'h0, 5'd0, 2'd0, 3'b000);
    @(negedge clk);
    reset = 1'b0;

    // Table: drive on the falling edge, check ZeroE before the rising edge and M outputs after it.
    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i], 5'(i + 1), 2'(i % 4));
      #1;
      chk($sformatf("v%0d.ZeroE", i), {31'd0, ZeroE}, {31'd0, vecs[i].e_zero});
      @(posedge clk);
      #1;
      chk_m($sformatf("v%0d", i), vecs[i].e_alu, vecs[i].e_wd, 5'(i + 1), 2'(i % 4), vecs[i].e_flags);
    end

    // Stall: load a known value, then hold for three cycles while E inputs change.
    @(negedge clk);
    drive(mk(3'b000,0,2'b00,2'b00,32'h30,32'h0C,32'h0,32'h0,1,1,1,32'h0,32'h0,3'b000,0), 5'd7, 2'd2);
    @(posedge clk);
    #1;
    chk_m("preload", 32'h3C, 32'h0C, 5'd7, 2'd2, 3'b111);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      StallM = 1'b1;
      drive(mk(3'b001,0,2'b10,2'b00,32'h0,32'h3C,32'h0,32'h0,0,0,1,32'h0,32'h0,3'b000,0),
            5'(20 + k), 2'd1);
      #1;
      // Held ALUResultM forwarded as SrcA minus 0x3C must be zero.
      chk($sformatf("stall%0d.ZeroE", k), {31'd0, ZeroE}, 32'd1);
      @(posedge clk);
      #1;
      chk_m($sformatf("stall%0d", k), 32'h3C, 32'h0C, 5'd7, 2'd2, 3'b111);
    end
    @(negedge clk);
    FlushM = 1'b1;
    @(posedge clk);
    #1;
    chk_m("stall_flush", 32'h0, 32'h0, 5'd0, 2'd0, 3'b000);
    @(negedge clk);
    StallM = 1'b0; FlushM = 1'b0;

    // Async reset between edges, then a normal load on the first edge after release.
    drive(mk(3'b011,0,2'b00,2'b00,32'hA0,32'h05,32'h0,32'h0,1,0,1,32'h0,32'h0,3'b000,0), 5'd9, 2'd3);
    @(posedge clk);
    #1;
    chk_m("pre_areset", 32'hA5, 32'h05, 5'd9, 2'd3, 3'b110);
    @(negedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk_m("areset", 32'h0, 32'h0, 5'd0, 2'd0, 3'b000);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk_m("post_release", 32'hA5, 32'h05, 5'd9, 2'd3, 3'b110);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
